// File: rtl/game_pkg.sv
// Shared types and constants for the two-player hit-point tracker.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } game_state_t;

    localparam logic [1:0] HP_MAX   = 2'd3;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    function automatic logic [1:0] hp_dec(input logic [1:0] hp);
        return (hp == 2'd0) ? 2'd0 : hp - 2'd1;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button plus rising-edge detector;
// emits a single-cycle pulse per press regardless of hold time.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/hp_tracker.sv
// Round state machine, per-player attack cooldowns and health registers feeding
// the seven-segment display stage.
module hp_tracker
    import game_pkg::*;
#(
    parameter int unsigned COOLDOWN_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn1,
    input  logic       btn2,
    input  logic       start,
    output logic [1:0] hp1,
    output logic [1:0] hp2,
    output logic       active,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int unsigned CW = (COOLDOWN_CYCLES < 1) ? 1 : $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_CYCLES);

    logic p1_pulse, p2_pulse, start_pulse;

    btn_sync_edge u_sync_btn1  (.clk(clk), .rst(rst), .raw(btn1),  .pulse(p1_pulse));
    btn_sync_edge u_sync_btn2  (.clk(clk), .rst(rst), .raw(btn2),  .pulse(p2_pulse));
    btn_sync_edge u_sync_start (.clk(clk), .rst(rst), .raw(start), .pulse(start_pulse));

    game_state_t   state_q, state_d;
    logic [1:0]    hp1_q, hp1_d, hp2_q, hp2_d;
    logic [CW-1:0] cd1_q, cd1_d, cd2_q, cd2_d;
    logic          active_q, active_d;
    logic          over_q, over_d;
    logic [1:0]    win_q, win_d;
    logic          accept1, accept2;

    always_comb begin
        state_d  = state_q;
        hp1_d    = hp1_q;
        hp2_d    = hp2_q;
        active_d = active_q;
        over_d   = over_q;
        win_d    = win_q;
        cd1_d    = (cd1_q != '0) ? cd1_q - CW'(1) : '0;
        cd2_d    = (cd2_q != '0) ? cd2_q - CW'(1) : '0;
        accept1  = 1'b0;
        accept2  = 1'b0;

        unique case (state_q)
            IDLE, OVER: begin
                // Start takes priority; attack pulses outside PLAY are discarded.
                if (start_pulse) begin
                    state_d  = PLAY;
                    hp1_d    = HP_MAX;
                    hp2_d    = HP_MAX;
                    cd1_d    = '0;
                    cd2_d    = '0;
                    active_d = 1'b1;
                    over_d   = 1'b0;
                    win_d    = WIN_NONE;
                end
            end
            PLAY: begin
                accept1 = p1_pulse && (cd1_q == '0);
                accept2 = p2_pulse && (cd2_q == '0);
                if (accept1) begin
                    hp2_d = hp_dec(hp2_q);
                    cd1_d = CD_LOAD;
                end
                if (accept2) begin
                    hp1_d = hp_dec(hp1_q);
                    cd2_d = CD_LOAD;
                end
                if (hp1_d == 2'd0 || hp2_d == 2'd0) begin
                    state_d  = OVER;
                    active_d = 1'b0;
                    over_d   = 1'b1;
                    if (hp1_d == 2'd0 && hp2_d == 2'd0) win_d = WIN_DRAW;
                    else if (hp2_d == 2'd0)             win_d = WIN_P1;
                    else                                win_d = WIN_P2;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hp1_q    <= HP_MAX;
            hp2_q    <= HP_MAX;
            cd1_q    <= '0;
            cd2_q    <= '0;
            active_q <= 1'b0;
            over_q   <= 1'b0;
            win_q    <= WIN_NONE;
        end else begin
            state_q  <= state_d;
            hp1_q    <= hp1_d;
            hp2_q    <= hp2_d;
            cd1_q    <= cd1_d;
            cd2_q    <= cd2_d;
            active_q <= active_d;
            over_q   <= over_d;
            win_q    <= win_d;
        end
    end

    assign hp1       = hp1_q;
    assign hp2       = hp2_q;
    assign active    = active_q;
    assign game_over = over_q;
    assign winner    = win_q;

endmodule

// File: tb/tb_hp_tracker.sv
// Scoreboard bench for hp_tracker: expected output changes (value and cycle) are
// queued by the stimulus and matched by a monitor whenever the outputs change.
module tb_hp_tracker;

    logic       clk = 1'b0;
    logic       rst, btn1, btn2, start;
    logic [1:0] hp1, hp2, winner;
    logic       active, game_over;

    hp_tracker #(.COOLDOWN_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .btn1(btn1), .btn2(btn2), .start(start),
        .hp1(hp1), .hp2(hp2), .active(active), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  out;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic [7:0]  prev;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mk(input logic [1:0] h1, input logic [1:0] h2,
                                      input logic a, input logic g, input logic [1:0] w);
        return {h1, h2, a, g, w};
    endfunction

    function automatic logic [7:0] outs();
        return {hp1, hp2, active, game_over, winner};
    endfunction

    function automatic void check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got hp1/hp2/act/over/win=%b expected %b at cycle %0d", name, got, want, cyc);
        end
    endfunction

    // Monitor: every change of the output tuple must match the next queued expectation.
    always @(negedge clk) begin
        logic [7:0] cur;
        exp_t       e;
        cur = outs();
        if (mon_en && cur !== prev) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_change: got %b with nothing expected at cycle %0d", cur, cyc);
            end else begin
                e = sb.pop_front();
                check("output_value", cur, e.out);
                n_checks++;
                if (cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL output_cycle: change to %b seen at cycle %0d expected cycle %0d", cur, cyc, e.cyc);
                end
            end
        end
        prev = cur;
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_in(input logic [7:0] o, input int unsigned dly);
        exp_t e;
        e.out = o;
        e.cyc = cyc + dly;
        sb.push_back(e);
    endtask

    task automatic press(input logic b1, input logic b2, input logic st, input int unsigned hold);
        if (b1) btn1 = 1'b1;
        if (b2) btn2 = 1'b1;
        if (st) start = 1'b1;
        tick(hold);
        btn1 = 1'b0;
        btn2 = 1'b0;
        start = 1'b0;
    endtask

    localparam logic [1:0] WN = 2'b00, W1 = 2'b01, WD = 2'b11;

    initial begin
        rst = 1'b1; btn1 = 1'b0; btn2 = 1'b0; start = 1'b0;
        tick(3);
        check("reset_state", outs(), mk(2'd3, 2'd3, 1'b0, 1'b0, WN));
        rst = 1'b0;
        tick(2);
        mon_en = 1'b1;
        tick(1);

        // Start from IDLE: PLAY two edges after start is first sampled.
        expect_in(mk(2'd3, 2'd3, 1'b1, 1'b0, WN), 3);
        press(1'b0, 1'b0, 1'b1, 1);
        tick(6);

        // Holding btn1 for 20 cycles yields one decrement.
        expect_in(mk(2'd3, 2'd2, 1'b1, 1'b0, WN), 3);
        press(1'b1, 1'b0, 1'b0, 20);
        tick(6);

        // Accepted, then a press 2 cycles later dropped, then 5 cycles later accepted.
        expect_in(mk(2'd3, 2'd1, 1'b1, 1'b0, WN), 3);
        press(1'b1, 1'b0, 1'b0, 1);
        tick(1);
        press(1'b1, 1'b0, 1'b0, 1);
        tick(2);
        expect_in(mk(2'd3, 2'd0, 1'b0, 1'b1, W1), 3);
        press(1'b1, 1'b0, 1'b0, 1);
        tick(6);

        // Attack in OVER ignored; start plus attack together: start wins.
        press(1'b0, 1'b1, 1'b0, 1);
        tick(6);
        expect_in(mk(2'd3, 2'd3, 1'b1, 1'b0, WN), 3);
        press(1'b0, 1'b1, 1'b1, 1);
        tick(6);

        // Draw round, with a btn1 press one cycle short of cooldown expiry dropped.
        expect_in(mk(2'd2, 2'd2, 1'b1, 1'b0, WN), 3);
        press(1'b1, 1'b1, 1'b0, 1);
        tick(3);
        press(1'b1, 1'b0, 1'b0, 1);
        tick(3);
        expect_in(mk(2'd1, 2'd1, 1'b1, 1'b0, WN), 3);
        press(1'b1, 1'b1, 1'b0, 1);
        tick(7);
        expect_in(mk(2'd0, 2'd0, 1'b0, 1'b1, WD), 3);
        press(1'b1, 1'b1, 1'b0, 1);
        tick(2);

        // Restart from OVER while cooldowns are still running: they must be cleared.
        expect_in(mk(2'd3, 2'd3, 1'b1, 1'b0, WN), 3);
        press(1'b0, 1'b0, 1'b1, 1);
        expect_in(mk(2'd2, 2'd2, 1'b1, 1'b0, WN), 3);
        press(1'b1, 1'b1, 1'b0, 1);
        tick(6);
        expect_in(mk(2'd2, 2'd1, 1'b1, 1'b0, WN), 3);
        press(1'b1, 1'b0, 1'b0, 1);
        tick(3);
        press(1'b0, 1'b0, 1'b1, 1);
        tick(6);

        // Asynchronous reset mid-round with health 2/1.
        expect_in(mk(2'd3, 2'd3, 1'b0, 1'b0, WN), 1);
        #2 rst = 1'b1;
        #1 check("async_reset", outs(), mk(2'd3, 2'd3, 1'b0, 1'b0, WN));
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        press(1'b1, 1'b0, 1'b0, 1);
        tick(6);
        expect_in(mk(2'd3, 2'd3, 1'b1, 1'b0, WN), 3);
        press(1'b0, 1'b0, 1'b1, 1);
        tick(10);

        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL pending_expectations: got %0d outstanding expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
